// File: rtl/hs_byte_tx_seq.sv
// High-speed lane byte sequencer: each burst is a 0x00 leader, a 0xB8 sync byte,
// the accepted payload and an inverted-last-bit trailer, followed by one gap cycle.
module hs_byte_tx_seq #(
  parameter int ZERO_BYTES  = 4,
  parameter int TRAIL_BYTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       clr_err,
  output logic [7:0] hs_byte,
  output logic       hs_valid,
  output logic       busy,
  output logic       underflow
);

  typedef enum logic [2:0] {IDLE, ZERO, SYNC, DATA, TRAIL, GAP} state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hB8;
  localparam logic [3:0] ZERO_LOAD  = 4'(ZERO_BYTES - 1);
  localparam logic [3:0] TRAIL_LOAD = 4'(TRAIL_BYTES - 1);

  generate
    if (ZERO_BYTES < 1 || ZERO_BYTES > 15 || TRAIL_BYTES < 1 || TRAIL_BYTES > 15) begin : g_bad_param
      $error("hs_byte_tx_seq: ZERO_BYTES and TRAIL_BYTES must be in 1..15");
    end
  endgenerate

  // Trailer drives the complement of the final lane bit (MSB, sent last).
  function automatic logic [7:0] trail_of(input logic [7:0] last_byte);
    return {8{~last_byte[7]}};
  endfunction

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hs_byte   <= 8'h00;
      hs_valid  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_err)
        underflow <= 1'b0;

      case (state)
        IDLE: begin
          hs_byte  <= 8'h00;
          hs_valid <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          if (in_valid) begin
            state    <= ZERO;
            cnt      <= ZERO_LOAD;
            hs_byte  <= 8'h00;
            hs_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ZERO: begin
          if (cnt == 4'd0) begin
            state    <= SYNC;
            hs_byte  <= SYNC_BYTE;
            in_ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        // in_ready is always set in SYNC; in DATA it drops once in_last is taken.
        SYNC, DATA: begin
          if (in_ready && in_valid) begin
            state    <= DATA;
            hs_byte  <= in_byte;
            in_ready <= ~in_last;
          end else begin
            state    <= TRAIL;
            cnt      <= TRAIL_LOAD;
            hs_byte  <= trail_of(hs_byte);
            in_ready <= 1'b0;
            if (in_ready)
              underflow <= 1'b1;
          end
        end

        TRAIL: begin
          if (cnt == 4'd0) begin
            state    <= GAP;
            hs_byte  <= 8'h00;
            hs_valid <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          hs_byte  <= 8'h00;
          hs_valid <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_byte_tx_seq.sv
// Bench for hs_byte_tx_seq: table-driven bursts, hand-written corner sequences,
// and random bursts compared against a burst-level reference of the lane stream.
module tb_hs_byte_tx_seq;

  localparam int Z = 4;
  localparam int T = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       clr_err = 1'b0;
  logic       in_ready;
  logic [7:0] hs_byte;
  logic       hs_valid;
  logic       busy;
  logic       underflow;

  hs_byte_tx_seq #(.ZERO_BYTES(Z), .TRAIL_BYTES(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .clr_err(clr_err),
    .hs_byte(hs_byte), .hs_valid(hs_valid), .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Lane monitor: every live byte and the underflow flag alongside it.
  logic [7:0] got[$];
  logic       ufq[$];
  int         rdy_cnt = 0, busy_cnt = 0, vrise = 0, zero_run = 0, prev_gap = -1;
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    if (hs_valid) begin
      got.push_back(hs_byte);
      ufq.push_back(underflow);
      if (!prev_v) begin
        vrise    <= vrise + 1;
        prev_gap <= zero_run;
      end
      zero_run <= 0;
    end else begin
      zero_run <= zero_run + 1;
    end
    if (in_ready) rdy_cnt <= rdy_cnt + 1;
    if (busy)     busy_cnt <= busy_cnt + 1;
    prev_v <= hs_valid;
  end

  logic [7:0] cur_pl[16];
  int g0, r0, b0, v0;

  typedef struct {
    int          n;
    bit          use_last;
    logic [31:0] pl;
    logic [7:0]  trail;
    bit          uf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_trail(input int n);
    logic [7:0] last;
    last = (n == 0) ? 8'hB8 : cur_pl[n-1];
    return last[7] ? 8'h00 : 8'hFF;
  endfunction

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("idle_hs_valid", hs_valid, 0);
    chk("idle_hs_byte", hs_byte, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
  endtask

  // Called in an IDLE cycle; returns in the next IDLE cycle.
  task automatic send_burst(input int n, input bit use_last, input bit hold, input bit clr_coll);
    int  k;
    bit  done;
    g0 = got.size(); r0 = rdy_cnt; b0 = busy_cnt; v0 = vrise;
    k = 0; done = 0;
    in_valid = 1'b1; in_byte = 8'($urandom); in_last = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1;
      end else if (in_ready) begin
        clr_err = 1'b0;
        if (k < n) begin
          in_valid = 1'b1;
          in_byte  = cur_pl[k];
          in_last  = use_last && (k == n - 1);
          k++;
        end else begin
          in_valid = 1'b0;
          in_byte  = 8'($urandom);
          in_last  = 1'($urandom);
          clr_err  = clr_coll;
        end
      end else begin
        clr_err  = 1'b0;
        in_valid = 1'($urandom);
        in_byte  = 8'($urandom);
        in_last  = 1'($urandom);
      end
    end
    if (!done) chk("burst_timeout", 0, 1);
    in_valid = hold; in_last = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_burst(input int n, input bit use_last, input logic [7:0] trail, input bit uf);
    logic [7:0] exp[$];
    int         len;
    exp = {};
    for (int i = 0; i < Z; i++) exp.push_back(8'h00);
    exp.push_back(8'hB8);
    for (int i = 0; i < n; i++) exp.push_back(cur_pl[i]);
    for (int i = 0; i < T; i++) exp.push_back(trail);
    len = got.size() - g0;
    chk("stream_len", len, exp.size());
    for (int i = 0; i < len && i < exp.size(); i++)
      chk($sformatf("stream_byte%0d", i), got[g0+i], exp[i]);
    if (len == exp.size()) begin
      chk("uf_before_trail", ufq[g0+Z+n], 0);
      chk("uf_at_trail", ufq[g0+Z+1+n], uf);
    end
    chk("ready_cycles", rdy_cnt - r0, use_last ? n : n + 1);
    chk("busy_cycles", busy_cnt - b0, exp.size() + 1);
    chk("valid_runs", vrise - v0, 1);
    chk("underflow_flag", underflow, uf);
  endtask

  initial begin
    vecs[0] = '{n: 3, use_last: 1, pl: 32'h0083_2211, trail: 8'h00, uf: 0};
    vecs[1] = '{n: 1, use_last: 1, pl: 32'h0000_007F, trail: 8'hFF, uf: 0};
    vecs[2] = '{n: 1, use_last: 0, pl: 32'h0000_0055, trail: 8'hFF, uf: 1};
    vecs[3] = '{n: 0, use_last: 0, pl: 32'h0000_0000, trail: 8'h00, uf: 1};

    // Asynchronous reset: outputs clear before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hs_valid", hs_valid, 0);
    chk("rst_hs_byte", hs_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_underflow", underflow, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_start", busy, 0);
    end

    foreach (vecs[v]) begin
      pulse_clr();
      chk("uf_cleared", underflow, 0);
      for (int i = 0; i < 4; i++) cur_pl[i] = vecs[v].pl[8*i +: 8];
      send_burst(vecs[v].n, vecs[v].use_last, 1'b0, 1'b0);
      check_burst(vecs[v].n, vecs[v].use_last, vecs[v].trail, vecs[v].uf);
      idle_check();
      idle_check();
      chk("uf_sticky", underflow, vecs[v].uf);
    end

    // Reset in the middle of the payload.
    pulse_clr();
    in_valid = 1'b1; in_byte = 8'h00;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_reach_sync", in_ready, 1);
    in_byte = 8'hA1;
    @(posedge clk); #1;
    in_byte = 8'hA2;
    @(posedge clk); #1;
    chk("mid_second_byte", hs_byte, 8'hA2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hs_valid", hs_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_hs_byte", hs_byte, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_trailer", hs_valid, 0);
    for (int i = 0; i < 3; i++) cur_pl[i] = vecs[0].pl[8*i +: 8];
    send_burst(3, 1'b1, 1'b0, 1'b0);
    check_burst(3, 1'b1, 8'h00, 1'b0);

    // Back-to-back bursts with in_valid held high across the boundary.
    idle_check();
    cur_pl[0] = 8'h3C; cur_pl[1] = 8'hC4;
    send_burst(2, 1'b1, 1'b1, 1'b0);
    check_burst(2, 1'b1, 8'h00, 1'b0);
    cur_pl[0] = 8'h9A; cur_pl[1] = 8'h12;
    send_burst(2, 1'b1, 1'b0, 1'b0);
    check_burst(2, 1'b1, 8'hFF, 1'b0);
    chk("b2b_gap_cycles", prev_gap, 2);

    // clr_err coinciding with an underflow: the set wins, then a later clear works.
    idle_check();
    pulse_clr();
    cur_pl[0] = 8'h01; cur_pl[1] = 8'h80;
    send_burst(2, 1'b0, 1'b0, 1'b1);
    check_burst(2, 1'b0, 8'h00, 1'b1);
    idle_check();
    chk("coll_uf_held", underflow, 1);
    pulse_clr();
    chk("coll_uf_cleared", underflow, 0);

    // Random bursts against the stream-level reference.
    for (int r = 0; r < 30; r++) begin
      int n;
      bit ul;
      n  = $urandom_range(0, 8);
      ul = (n > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) cur_pl[i] = 8'($urandom);
      pulse_clr();
      send_burst(n, ul, 1'b0, ($urandom_range(0, 1) == 1));
      check_burst(n, ul, model_trail(n), !ul);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
